// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Optional duty-cycle control is enabled with CLK_DIV_DUTY_EN.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 16;

  function automatic logic [31:0] clamp_div(input logic [31:0] n);
    return (n < 32'd2) ? 32'd2 : n;
  endfunction

  function automatic logic [31:0] default_high(input logic [31:0] n);
    return (n >> 1) + {31'd0, n[0]};
  endfunction

  // High time must leave at least one low cycle and one high cycle.
  function automatic logic [31:0] clamp_high(input logic [31:0] h, input logic [31:0] n);
    if (h < 32'd1)           return 32'd1;
    else if (h > n - 32'd1)  return n - 32'd1;
    else                     return h;
  endfunction

endpackage

// File: rtl/clk_div_reload_ctrl.sv
// Pending-ratio register, clamp and acknowledge for the clock divider.
// Under CLK_DIV_DUTY_EN the high time is captured and applied with the ratio.
module clk_div_reload_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_div,
`ifdef CLK_DIV_DUTY_EN
  input  logic [CNT_W-1:0] i_high,
`endif
  input  logic             i_apply,
  output logic             o_ack,
  output logic [CNT_W-1:0] o_div,
  output logic [CNT_W-1:0] o_high
);

  localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(default_high(32'(DEFAULT_DIV)));

  logic [CNT_W-1:0] r_pend_div, r_pend_high, r_div, r_high;
  logic             r_pend_vld, r_ack;
  logic [CNT_W-1:0] w_cap_div, w_cap_high, w_new_div, w_new_high;
  logic             w_new_vld;

  assign w_cap_div  = CNT_W'(clamp_div(32'(i_div)));
`ifdef CLK_DIV_DUTY_EN
  assign w_cap_high = CNT_W'(clamp_high(32'(i_high), 32'(w_cap_div)));
`else
  assign w_cap_high = CNT_W'(default_high(32'(w_cap_div)));
`endif

  // A load coinciding with the apply strobe bypasses the pending register.
  assign w_new_vld  = i_load | r_pend_vld;
  assign w_new_div  = i_load ? w_cap_div  : r_pend_div;
  assign w_new_high = i_load ? w_cap_high : r_pend_high;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend_div  <= DEF_N;
      r_pend_high <= DEF_H;
      r_pend_vld  <= 1'b0;
      r_div       <= DEF_N;
      r_high      <= DEF_H;
      r_ack       <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (i_apply && w_new_vld) begin
        r_div      <= w_new_div;
        r_high     <= w_new_high;
        r_ack      <= 1'b1;
        r_pend_vld <= 1'b0;
      end else if (i_load) begin
        r_pend_div  <= w_cap_div;
        r_pend_high <= w_cap_high;
        r_pend_vld  <= 1'b1;
      end
    end
  end

  assign o_ack  = r_ack;
  assign o_div  = r_div;
  assign o_high = r_high;

endmodule

// File: rtl/clock_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free reload and drain.
// Defining CLK_DIV_DUTY_EN adds the HIGH_CYCLES port for programmable duty.
module clock_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             INPUT_CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [CNT_W-1:0] DIV_VALUE,
  input  logic             DIV_LOAD,
`ifdef CLK_DIV_DUTY_EN
  input  logic [CNT_W-1:0] HIGH_CYCLES,
`endif
  output logic             DIV_ACK,
  output logic [CNT_W-1:0] ACTIVE_DIV,
  output logic             OUTPUT_CLK,
  output logic             OUTPUT_TICK
);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_div, w_high, w_cnt_inc;
  logic             r_clk, w_clk_nxt, r_tick, w_tick_nxt;
  logic             w_wrap, w_apply;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_wrap    = (r_state != IDLE) && (r_cnt == w_div - CNT_W'(1));
  assign w_apply   = (r_state == IDLE) || w_wrap;

  clk_div_reload_ctrl #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_reload (
    .i_clk   (INPUT_CLK),
    .i_rst   (RST),
    .i_load  (DIV_LOAD),
    .i_div   (DIV_VALUE),
`ifdef CLK_DIV_DUTY_EN
    .i_high  (HIGH_CYCLES),
`endif
    .i_apply (w_apply),
    .o_ack   (DIV_ACK),
    .o_div   (w_div),
    .o_high  (w_high)
  );

  always_ff @(posedge INPUT_CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_clk   <= w_clk_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  // RUN and DRAIN count identically; EN only matters at the period wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clk_nxt   = r_clk;
    w_tick_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_clk_nxt = 1'b0;
        if (EN) begin
          w_state_nxt = RUN;
          w_clk_nxt   = 1'b1;
          w_tick_nxt  = 1'b1;
        end
      end
      RUN, DRAIN: begin
        if (w_wrap) begin
          w_cnt_nxt   = '0;
          w_state_nxt = EN ? RUN : IDLE;
          w_clk_nxt   = EN;
          w_tick_nxt  = EN;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
          w_clk_nxt   = (w_cnt_inc < w_high);
          w_state_nxt = EN ? RUN : DRAIN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_clk_nxt   = 1'b0;
      end
    endcase
  end

  assign ACTIVE_DIV  = w_div;
  assign OUTPUT_CLK  = r_clk;
  assign OUTPUT_TICK = r_tick;

endmodule

// File: tb/tb_clock_div_prog.sv
// Directed bench for clock_div_prog: vector table plus hand-written corner sequences.
module tb_clock_div_prog;

  logic        clk = 1'b0;
  logic        RST, EN, DIV_LOAD;
  logic [15:0] DIV_VALUE;
  logic [15:0] HIGH_IN;
  logic        DIV_ACK, OUTPUT_CLK, OUTPUT_TICK;
  logic [15:0] ACTIVE_DIV;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_div_prog #(.CNT_W(16), .DEFAULT_DIV(2)) dut (
    .INPUT_CLK   (clk),
    .RST         (RST),
    .EN          (EN),
    .DIV_VALUE   (DIV_VALUE),
    .DIV_LOAD    (DIV_LOAD),
`ifdef CLK_DIV_DUTY_EN
    .HIGH_CYCLES (HIGH_IN),
`endif
    .DIV_ACK     (DIV_ACK),
    .ACTIVE_DIV  (ACTIVE_DIV),
    .OUTPUT_CLK  (OUTPUT_CLK),
    .OUTPUT_TICK (OUTPUT_TICK)
  );

  typedef struct {
    int en, ld, val, oclk, tick, ack, div;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic chk_out(input string n, input int ec, input int et, input int ea, input int ed);
    chk({n, " clk"},  32'(OUTPUT_CLK),  32'(ec));
    chk({n, " tick"}, 32'(OUTPUT_TICK), 32'(et));
    chk({n, " ack"},  32'(DIV_ACK),     32'(ea));
    chk({n, " div"},  32'(ACTIVE_DIV),  32'(ed));
  endtask

  // Inputs set here are sampled at the next posedge; outputs read 1 ns after it.
  task automatic cyc(input logic en, input logic ld, input logic [15:0] val);
    EN = en; DIV_LOAD = ld; DIV_VALUE = val;
    @(posedge clk); #1;
    DIV_LOAD = 1'b0;
  endtask

  initial begin
    int hi_cnt;
    RST = 1'b1; EN = 1'b0; DIV_LOAD = 1'b0; DIV_VALUE = '0; HIGH_IN = '0;

    tbl[0]  = '{1,0,0, 1,1,0,2};
    tbl[1]  = '{1,0,0, 0,0,0,2};
    tbl[2]  = '{1,0,0, 1,1,0,2};
    tbl[3]  = '{1,0,0, 0,0,0,2};
    tbl[4]  = '{1,0,0, 1,1,0,2};
    tbl[5]  = '{1,1,5, 0,0,0,2};
    tbl[6]  = '{1,0,0, 1,1,1,5};
    tbl[7]  = '{1,0,0, 1,0,0,5};
    tbl[8]  = '{1,0,0, 1,0,0,5};
    tbl[9]  = '{1,0,0, 0,0,0,5};
    tbl[10] = '{1,0,0, 0,0,0,5};
    tbl[11] = '{1,0,0, 1,1,0,5};
    tbl[12] = '{1,1,7, 1,0,0,5};
    tbl[13] = '{1,1,4, 1,0,0,5};
    tbl[14] = '{1,0,0, 0,0,0,5};
    tbl[15] = '{1,0,0, 0,0,0,5};
    tbl[16] = '{1,0,0, 1,1,1,4};
    tbl[17] = '{1,0,0, 1,0,0,4};
    tbl[18] = '{1,0,0, 0,0,0,4};
    tbl[19] = '{1,0,0, 0,0,0,4};
    tbl[20] = '{1,0,0, 1,1,0,4};

    repeat (2) @(posedge clk);
    #1 RST = 1'b0;
    chk_out("reset", 0, 0, 0, 2);

    // Default ratio, load 5 at the wrap, then loads 7/4 collapsing to one ack.
    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].en[0], tbl[i].ld[0], 16'(tbl[i].val));
      chk_out($sformatf("vec%0d", i), tbl[i].oclk, tbl[i].tick, tbl[i].ack, tbl[i].div);
    end

    // Switch to N=6, then drop EN at cnt=1 and drain.
    cyc(1, 1, 6);  chk_out("n6 ld", 1, 0, 0, 4);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);  chk_out("n6 wrap", 1, 1, 1, 6);
    cyc(1, 0, 0);  chk_out("n6 cnt1", 1, 0, 0, 6);
    cyc(0, 0, 0);  chk_out("drain hi", 1, 0, 0, 6);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0); chk_out($sformatf("drain lo%0d", i), 0, 0, 0, 6);
    end
    cyc(0, 0, 0);  chk_out("idle0", 0, 0, 0, 6);
    cyc(0, 0, 0);  chk_out("idle1", 0, 0, 0, 6);

    // Restart, drop EN in low phase, re-assert: period must close without a gap.
    cyc(1, 0, 0);  chk_out("restart", 1, 1, 0, 6);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);  chk_out("lo drain", 0, 0, 0, 6);
    cyc(1, 0, 0);
    cyc(1, 0, 0);  chk_out("lo rerun", 0, 0, 0, 6);
    cyc(1, 0, 0);  chk_out("no gap", 1, 1, 0, 6);

    // Load 0 clamps to 2 and is acknowledged at the wrap.
    cyc(1, 1, 0);  chk_out("ld0", 1, 0, 0, 6);
    repeat (4) cyc(1, 0, 0);
    cyc(1, 0, 0);  chk_out("ld0 wrap", 1, 1, 1, 2);
    cyc(1, 0, 0);  chk_out("n2 cnt1", 0, 0, 0, 2);
    // Load on the last count of the period takes effect immediately.
    cyc(1, 1, 3);  chk_out("bypass", 1, 1, 1, 3);
    cyc(1, 0, 0);  chk_out("n3 cnt1", 1, 0, 0, 3);
    cyc(1, 0, 0);  chk_out("n3 cnt2", 0, 0, 0, 3);
    cyc(1, 0, 0);  chk_out("n3 wrap", 1, 1, 0, 3);

    // Load during drain lands at the final wrap; block idles with it.
    cyc(0, 1, 5);  chk_out("drain ld", 1, 0, 0, 3);
    cyc(0, 0, 0);  chk_out("drain ld lo", 0, 0, 0, 3);
    cyc(0, 0, 0);  chk_out("drain ld wrap", 0, 0, 1, 5);
    cyc(0, 0, 0);  chk_out("drain ld idle", 0, 0, 0, 5);

    // Asynchronous reset in the middle of the high phase.
    cyc(1, 0, 0);  chk_out("pre rst", 1, 1, 0, 5);
    cyc(1, 0, 0);  chk_out("pre rst hi", 1, 0, 0, 5);
    #2 RST = 1'b1;
    #1 chk_out("async rst", 0, 0, 0, 2);
    @(negedge clk); RST = 1'b0;
    cyc(0, 0, 0);  chk_out("post rst", 0, 0, 0, 2);
    cyc(1, 0, 0);  chk_out("post rst run", 1, 1, 0, 2);

`ifdef CLK_DIV_DUTY_EN
    @(negedge clk); RST = 1'b1;
    @(negedge clk); RST = 1'b0;
    HIGH_IN = 16'd0;
    cyc(0, 1, 8);  chk_out("duty0 ld", 0, 0, 1, 8);
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0); hi_cnt += int'(OUTPUT_CLK);
    end
    chk("duty0 high", 32'(hi_cnt), 32'd1);
    HIGH_IN = 16'd9;
    cyc(1, 1, 8);  chk_out("duty9 wrap", 1, 1, 1, 8);
    hi_cnt = 1;
    for (int i = 0; i < 7; i++) begin
      cyc(1, 0, 0); hi_cnt += int'(OUTPUT_CLK);
    end
    chk("duty9 high", 32'(hi_cnt), 32'd7);
`else
    hi_cnt = 0;
    chk("nodut hi_cnt", 32'(hi_cnt + int'(OUTPUT_CLK)), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
